// File: rtl/masku_mask_packer.sv
// Packs the LSB of each shuffled lane element into sequential mask words and
// buffers the finished words, with bit enables and a last flag, in a small FIFO.
module masku_mask_packer #(
  parameter int unsigned NrLanes      = 4,
  parameter int unsigned OutFifoDepth = 2,
  parameter int unsigned VlWidth      = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic [VlWidth-1:0]           vl_i,
  input  logic [1:0]                   vsew_i,
  output logic                         busy_o,
  input  logic                         operand_valid_i,
  output logic                         operand_ready_o,
  input  logic [NrLanes-1:0][63:0]     operand_i,
  output logic                         result_valid_o,
  input  logic                         result_ready_i,
  output logic [NrLanes*64-1:0]        result_o,
  output logic [NrLanes*64-1:0]        result_be_o,
  output logic                         result_last_o,
  output logic                         done_o
);

  localparam int unsigned W    = NrLanes * 64;
  localparam int unsigned MaxE = NrLanes * 8;
  localparam int unsigned PtrW = $clog2(W) + 1;
  localparam int unsigned IdxW = (OutFifoDepth > 1) ? $clog2(OutFifoDepth) : 1;
  localparam int unsigned CntW = $clog2(OutFifoDepth + 1);

  typedef enum logic [1:0] {IDLE, PACK, DRAIN} state_e;

  typedef struct packed {
    logic         last;
    logic [W-1:0] be;
    logic [W-1:0] data;
  } entry_t;

  state_e                           state_q, state_d;
  logic [VlWidth-1:0]               remaining_q, remaining_d;
  logic [1:0]                       vsew_q, vsew_d;
  logic [PtrW-1:0]                  ptr_q, ptr_d;
  logic [W-1:0]                     acc_q, acc_d;
  logic [W-1:0]                     en_q, en_d;
  logic                             done_q, done_d;
  entry_t [OutFifoDepth-1:0]        fifo_q, fifo_d;
  logic [IdxW-1:0]                  wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]                  cnt_q, cnt_d;

  logic [VlWidth-1:0] elems, valid_cnt, rem_after;
  logic [MaxE-1:0]    beat_bits, beat_en;
  logic [W-1:0]       word_data, word_be;
  logic               beat_fire, word_full, push, pop, fifo_full;
  entry_t             head, push_entry;

  function automatic logic [IdxW-1:0] idx_next(input logic [IdxW-1:0] idx);
    return (idx == IdxW'(OutFifoDepth - 1)) ? '0 : idx + 1'b1;
  endfunction

  assign elems     = VlWidth'(MaxE) >> vsew_q;
  assign valid_cnt = (remaining_q < elems) ? remaining_q : elems;
  assign rem_after = remaining_q - valid_cnt;

  // Element i lives in lane i mod NrLanes at byte slot (i div NrLanes) << vsew.
  for (genvar gi = 0; gi < MaxE; gi++) begin : g_elem
    localparam int unsigned Lane = gi % NrLanes;
    localparam int unsigned Slot = gi / NrLanes;
    logic [5:0] bit_idx;
    assign bit_idx       = 6'(((Slot << vsew_q) % 8) * 8);
    assign beat_en[gi]   = VlWidth'(gi) < valid_cnt;
    assign beat_bits[gi] = beat_en[gi] & operand_i[Lane][bit_idx];
  end

  assign word_data  = acc_q | (W'(beat_bits) << ptr_q);
  assign word_be    = en_q | (W'(beat_en) << ptr_q);
  assign word_full  = (ptr_q + PtrW'(elems)) == PtrW'(W);

  assign fifo_full       = cnt_q == CntW'(OutFifoDepth);
  assign result_valid_o  = cnt_q != '0;
  assign head            = fifo_q[rd_q];
  assign result_o        = result_valid_o ? head.data : '0;
  assign result_be_o     = result_valid_o ? head.be : '0;
  assign result_last_o   = result_valid_o & head.last;
  assign operand_ready_o = (state_q == PACK) && !fifo_full;
  assign beat_fire       = operand_valid_i && operand_ready_o;
  assign pop             = result_valid_o && result_ready_i;
  assign busy_o          = state_q != IDLE;
  assign done_o          = done_q;

  assign push_entry = '{last: (rem_after == '0), be: word_be, data: word_data};

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    vsew_d      = vsew_q;
    ptr_d       = ptr_q;
    acc_d       = acc_q;
    en_d        = en_q;
    done_d      = 1'b0;
    push        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          remaining_d = vl_i;
          vsew_d      = vsew_i;
          ptr_d       = '0;
          acc_d       = '0;
          en_d        = '0;
          if (vl_i == '0) done_d = 1'b1;
          else            state_d = PACK;
        end
      end
      PACK: begin
        if (beat_fire) begin
          remaining_d = rem_after;
          ptr_d       = ptr_q + PtrW'(elems);
          acc_d       = word_data;
          en_d        = word_be;
          if (word_full || rem_after == '0) begin
            push  = 1'b1;
            ptr_d = '0;
            acc_d = '0;
            en_d  = '0;
          end
          if (rem_after == '0) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head.last) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Ready never looks at result_ready_i, so push-when-full cannot occur.
  always_comb begin
    fifo_d = fifo_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    if (push) begin
      fifo_d[wr_q] = push_entry;
      wr_d         = idx_next(wr_q);
    end
    if (pop) rd_d = idx_next(rd_q);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      vsew_q      <= '0;
      ptr_q       <= '0;
      acc_q       <= '0;
      en_q        <= '0;
      done_q      <= 1'b0;
      fifo_q      <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      vsew_q      <= vsew_d;
      ptr_q       <= ptr_d;
      acc_q       <= acc_d;
      en_q        <= en_d;
      done_q      <= done_d;
      fifo_q      <= fifo_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
    end
  end

  a_start_ignored: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (start_i && state_q != IDLE) |=> $stable(vsew_q));

endmodule
